// File: rtl/bpred_pc_if.sv
`default_nettype none
// ============================================================================
// Module      : bpred_pc_if
// Description : Fetch-stage bundle between the pipeline and the branch
//               predictor / PC generator (redirects, BHT update, fetch PC).
// Revision    : 1.0 - initial release
// ============================================================================
interface bpred_pc_if #(
  parameter int PC_SIZE = 32
);

  // Fetch control and the fetched instruction
  logic                stall;
  logic [31:0]         instr;

  // Decode-stage JALR redirect
  logic                id_jalr;
  logic [PC_SIZE-1:0]  id_reg_value;

  // Execute-stage corrective redirect
  logic                predict_fail;
  logic [PC_SIZE-1:0]  bxx_fail_pc;
  logic [PC_SIZE-1:0]  bxx_fail_imm;

  // Resolved-branch training port
  logic                upd_valid;
  logic [PC_SIZE-1:0]  upd_pc;
  logic                upd_taken;

  // Predictor outputs
  logic [PC_SIZE-1:0]  pc;
  logic [PC_SIZE-1:0]  pc_next;
  logic                take;
  logic                instr_nop_sel;
  logic [15:0]         mispred_cnt;

  // Pipeline side: drives fetch/redirect/training, observes the PC
  modport master (
    output stall, instr, id_jalr, id_reg_value,
           predict_fail, bxx_fail_pc, bxx_fail_imm,
           upd_valid, upd_pc, upd_taken,
    input  pc, pc_next, take, instr_nop_sel, mispred_cnt
  );

  // Predictor side
  modport slave (
    input  stall, instr, id_jalr, id_reg_value,
           predict_fail, bxx_fail_pc, bxx_fail_imm,
           upd_valid, upd_pc, upd_taken,
    output pc, pc_next, take, instr_nop_sel, mispred_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bpred_pc.sv
`default_nettype none
// ============================================================================
// Module      : bpred_pc
// Description : Fetch PC generator with a 2-bit saturating-counter branch
//               history table (or a static backward-taken predictor),
//               JAL/B-type immediate decode, redirect priority and a
//               saturating misprediction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_pc #(
  parameter int                 PC_SIZE     = 32,
  parameter int                 BHT_DEPTH   = 64,     // power of two, 4..1024
  parameter logic [PC_SIZE-1:0] RESET_PC    = '0,
  parameter logic [1:0]         CNT_INIT    = 2'b01,  // weakly not-taken
  parameter bit                 STATIC_MODE = 1'b0
) (
  input  wire          clk,
  input  wire          rst,
  bpred_pc_if.slave    bus
);

  // Word-aligned index width; the BHT is addressed by pc[c_idx_w+1:2]
  localparam int                 c_idx_w   = $clog2(BHT_DEPTH);
  localparam logic [6:0]         c_op_jal  = 7'b1101111;
  localparam logic [6:0]         c_op_bxx  = 7'b1100011;
  localparam logic [PC_SIZE-1:0] c_pc_step = PC_SIZE'(4);
  localparam logic [1:0]         c_cnt_max = 2'b11;
  localparam logic [1:0]         c_cnt_min = 2'b00;
  localparam logic [15:0]        c_mis_max = 16'hFFFF;

  // State
  logic [PC_SIZE-1:0] r_pc;
  logic [1:0]         r_bht [BHT_DEPTH];
  logic [15:0]        r_mispred_cnt;

  // Decode / lookup
  logic [c_idx_w-1:0] w_idx;
  logic [c_idx_w-1:0] w_uidx;
  logic               w_jal;
  logic               w_bxx;
  logic [PC_SIZE-1:0] w_jimm;
  logic [PC_SIZE-1:0] w_bimm;
  logic [1:0]         w_cnt_cur;
  logic               w_take;

  // Next-state
  logic [PC_SIZE-1:0] w_pc_next;
  logic               w_redirect;
  logic               w_pc_load;
  logic [1:0]         w_cnt_old;
  logic [1:0]         w_cnt_new;

  // Only the index bits of the update PC select a counter
  logic               w_unused_upd_bits;

  assign w_idx  = r_pc[c_idx_w+1:2];
  assign w_uidx = bus.upd_pc[c_idx_w+1:2];
  assign w_unused_upd_bits = ^{bus.upd_pc[PC_SIZE-1:c_idx_w+2], bus.upd_pc[1:0]};

  // Opcode decode and sign-extended J/B immediates of the fetched instruction
  always_comb begin
    w_jal  = (bus.instr[6:0] == c_op_jal);
    w_bxx  = (bus.instr[6:0] == c_op_bxx);
    w_jimm = {{(PC_SIZE-21){bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
              bus.instr[20], bus.instr[30:21], 1'b0};
    w_bimm = {{(PC_SIZE-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
              bus.instr[30:25], bus.instr[11:8], 1'b0};
  end

  // Direction prediction: BHT MSB, or sign of the branch offset in static mode.
  // The lookup reads the registered counter, so a same-cycle update of the
  // same entry only becomes visible on the following cycle.
  always_comb begin
    w_cnt_cur = r_bht[w_idx];
    if (STATIC_MODE) begin
      w_take = w_bxx & bus.instr[31];
    end else begin
      w_take = w_bxx & w_cnt_cur[1];
    end
  end

  // Next-PC selection; execute-stage correction outranks decode JALR,
  // which outranks the fetch-stage prediction. Sums wrap silently.
  always_comb begin
    w_pc_next = r_pc + c_pc_step;
    if (bus.predict_fail) begin
      w_pc_next = bus.bxx_fail_pc + bus.bxx_fail_imm;
    end else if (bus.id_jalr) begin
      w_pc_next = r_pc + bus.id_reg_value;
    end else if (w_take) begin
      w_pc_next = r_pc + w_bimm;
    end else if (w_jal) begin
      w_pc_next = r_pc + w_jimm;
    end
  end

  // A redirect must not be lost behind fetch back-pressure
  assign w_redirect = bus.predict_fail | bus.id_jalr;
  assign w_pc_load  = ~bus.stall | w_redirect;

  // Fetch PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_pc_load) begin
      r_pc <= w_pc_next;
    end
  end

  // Saturating increment/decrement of the counter being trained
  always_comb begin
    w_cnt_old = r_bht[w_uidx];
    w_cnt_new = w_cnt_old;
    if (bus.upd_taken) begin
      if (w_cnt_old != c_cnt_max) begin
        w_cnt_new = w_cnt_old + 2'b01;
      end
    end else begin
      if (w_cnt_old != c_cnt_min) begin
        w_cnt_new = w_cnt_old - 2'b01;
      end
    end
  end

  // BHT training; runs through stalls and in static mode alike
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= CNT_INIT;
      end
    end else if (bus.upd_valid) begin
      r_bht[w_uidx] <= w_cnt_new;
    end
  end

  // Misprediction counter, one per cycle of predict_fail, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mispred_cnt <= '0;
    end else if (bus.predict_fail && (r_mispred_cnt != c_mis_max)) begin
      r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pc_next       = w_pc_next;
  assign bus.take          = w_take;
  assign bus.instr_nop_sel = w_redirect;
  assign bus.mispred_cnt   = r_mispred_cnt;

endmodule
`default_nettype wire

// File: doc/bpred_pc.md
BPRED_PC -- requirements
Module: bpred_pc

Interface
REQ-001 Parameter PC_SIZE, default 32: width of every PC/address/immediate port.
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit counters; power of two, 4..1024.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-004 Parameter CNT_INIT, default 2'b01: counter reset value (weakly not-taken).
REQ-005 Parameter STATIC_MODE, default 0: 1 = predict taken iff B-type offset negative; BHT ignored for prediction.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 stall  in  1  hold PC (fetch back-pressure).
REQ-009 instr  in  32  instruction fetched at pc.
REQ-010 id_jalr  in  1  JALR resolved in decode; redirect.
REQ-011 id_reg_value  in  PC_SIZE  offset added to pc for JALR redirect.
REQ-012 predict_fail  in  1  branch misprediction from execute.
REQ-013 bxx_fail_pc  in  PC_SIZE  base PC of corrective redirect.
REQ-014 bxx_fail_imm  in  PC_SIZE  offset of corrective redirect.
REQ-015 upd_valid  in  1  resolved-branch update strobe.
REQ-016 upd_pc  in  PC_SIZE  PC of resolved branch.
REQ-017 upd_taken  in  1  actual outcome of resolved branch.
REQ-018 pc  out  PC_SIZE  registered fetch PC.
REQ-019 pc_next  out  PC_SIZE  combinational next PC.
REQ-020 take  out  1  prediction for instr (valid when instr is B-type).
REQ-021 instr_nop_sel  out  1  squash fetched instr; = id_jalr | predict_fail.
REQ-022 mispred_cnt  out  16  saturating misprediction count.

Function
REQ-023 Index idx = pc[log2(BHT_DEPTH)+1:2]; update index uidx = upd_pc[same bits].
REQ-024 Decode: jal = opcode 7'b1101111, bxx = opcode 7'b1100011.
REQ-025 take = bxx & (STATIC_MODE ? instr[31] : bht[idx][1]); take=0 for non-B-type.
REQ-026 J imm = sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],0}; B imm = sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-027 pc_next priority: predict_fail -> bxx_fail_pc+bxx_fail_imm; id_jalr -> pc+id_reg_value; bxx&take -> pc+Bimm; jal -> pc+Jimm; else pc+4.
REQ-028 All sums modulo 2^PC_SIZE; wrap-around is silent, no flag.
REQ-029 pc loads pc_next on each edge when stall=0; when stall=1, pc holds unless predict_fail or id_jalr=1, which load regardless (redirect beats stall).
REQ-030 On upd_valid: taken -> bht[uidx] increments, saturating at 2'b11; not-taken -> decrements, saturating at 2'b00; other entries unchanged.
REQ-031 BHT update independent of stall; update also performed when STATIC_MODE=1.
REQ-032 Same-cycle lookup and update of one index: lookup sees pre-update value; new value visible next cycle.
REQ-033 mispred_cnt increments by 1 each cycle predict_fail=1; saturates at 16'hFFFF.
REQ-034 Latency: prediction and pc_next same cycle as instr; redirect reflected on pc one edge later.

Reset
REQ-035 rst=1 asynchronously forces pc=RESET_PC, every bht entry=CNT_INIT, mispred_cnt=0, regardless of clk.
REQ-036 During reset, pc_next/take/instr_nop_sel follow REQ-025..027 from reset state; pc not loaded.
REQ-037 Reset asserted mid-stall or mid-redirect: reset wins; first edge after deassert loads pc_next computed from RESET_PC.

Verification
REQ-038 Reset, instr=NOP 32'h00000013, stall=0, 3 edges -> pc 0x0,0x4,0x8,0xC.
REQ-039 pc=0x100, instr=beq offset -8, bht entry=01 -> take=0, pc_next=0x104; after two upd_valid taken for 0x100 -> entry 11, take=1, pc_next=0x0F8.
REQ-040 Four upd_taken=1 then one upd_taken=0 on same index -> counter 11 saturated then 10; take stays 1.
REQ-041 stall=1 with jal at pc=0x40 offset +0x20 -> pc holds 0x40; same cycle predict_fail=1, bxx_fail_pc=0x80, imm=0xC -> pc=0x8C, instr_nop_sel=1, mispred_cnt +1.
REQ-042 pc=0xFFFF_FFFC, NOP -> pc wraps to 0x0; STATIC_MODE=1, beq offset +8 -> take=0 regardless of bht.
REQ-043 Async rst pulse between edges with pc=0x200 -> pc=RESET_PC immediately, bht=CNT_INIT, mispred_cnt=0.
